// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants, FSM encoding and access-size helpers for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Access size in bytes; funct3 values that fault elsewhere simply report 4.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            3'd0, 3'd4: return 3'd1;
            3'd1, 3'd5: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - byte-addressed data memory port between the LSU and the memory
interface lsu_mem_port_if #(
    parameter int ADDR_W = 16
);
    logic [3:0]        mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output mem_w_en,
        output mem_address,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_w_en,
        input  mem_address,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of raw load data selected by funct3
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   data = raw;
            F3_LBU:  data = {24'd0, raw[7:0]};
            F3_LHU:  data = {16'd0, raw[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit driving one memory access per request with tagged responses
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 16,
    parameter int TAG_W            = 5,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_fault,
    lsu_mem_port_if.master    mem
);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_fault_q, rsp_fault_d;

    logic [2:0]         req_size;
    logic [ADDR_W:0]    req_last;
    logic               illegal_f3, out_of_range, misaligned, req_fault, accept;
    logic [31:0]        load_data;

    lsu_load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (mem.mem_read_data),
        .data   (load_data)
    );

    // The last byte is computed one bit wider so an access running past the top is caught, not wrapped.
    always_comb begin
        req_size     = size_of(req_funct3);
        illegal_f3   = req_we ? (req_funct3 > 3'd2)
                              : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        req_last     = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(req_size) - (ADDR_W+1)'(1);
        out_of_range = (req_addr[31:ADDR_W] != '0) || req_last[ADDR_W];
        misaligned   = !ALLOW_MISALIGNED &&
                       ((req_size == 3'd2 && req_addr[0]) ||
                        (req_size == 3'd4 && req_addr[1:0] != 2'd0));
        req_fault    = illegal_f3 || out_of_range || misaligned;
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;

        req_ready = (state_q == IDLE) || (state_q == RESP && rsp_ready);
        accept    = req_valid && req_ready;

        if (accept) begin
            we_d        = req_we;
            funct3_d    = req_funct3;
            addr_d      = req_addr[ADDR_W-1:0];
            wdata_d     = req_wdata;
            tag_d       = req_tag;
            rsp_fault_d = req_fault;
            if (req_fault) begin
                rsp_data_d = '0;
                state_d    = RESP;
            end else begin
                state_d    = ACCESS;
            end
        end else begin
            case (state_q)
                ACCESS: begin
                    rsp_data_d = we_q ? 32'd0 : load_data;
                    state_d    = RESP;
                end
                RESP:    if (rsp_ready) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Memory drive decodes straight from the state flop so an async reset kills w_en at once.
    always_comb begin
        mem.mem_w_en       = '0;
        mem.mem_address    = '0;
        mem.mem_write_data = '0;
        if (state_q == ACCESS) begin
            mem.mem_address = addr_q;
            if (we_q) begin
                mem.mem_w_en       = byte_mask(size_of(funct3_q));
                mem.mem_write_data = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = tag_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port against a byte-array reference model
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_fault;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_data;
    logic [4:0]  req_tag, rsp_tag;

    logic        s_req_valid, s_req_ready, s_req_we, s_rsp_valid, s_rsp_ready, s_rsp_fault;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_data;
    logic [4:0]  s_req_tag, s_rsp_tag;

    lsu_mem_port_if #(.ADDR_W(16)) mif ();
    lsu_mem_port_if #(.ADDR_W(16)) smif ();

    lsu_mem_port #(.ADDR_W(16), .TAG_W(5), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_fault(rsp_fault), .mem(mif)
    );

    lsu_mem_port #(.ADDR_W(16), .TAG_W(5), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_tag(s_req_tag),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .rsp_tag(s_rsp_tag), .rsp_fault(s_rsp_fault), .mem(smif)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign mif.mem_read_data = {mem[mif.mem_address + 16'd3], mem[mif.mem_address + 16'd2],
                                mem[mif.mem_address + 16'd1], mem[mif.mem_address]};
    assign smif.mem_read_data = 32'h1234_8001;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (mif.mem_w_en[k]) mem[mif.mem_address + 16'(k)] = mif.mem_write_data[8*k +: 8];
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit allow,
                              output bit fault, output logic [31:0] data, output logic [3:0] mask);
        longint a, v;
        int     size;
        bit     legal;
        a     = {32'd0, addr};
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        size  = 1 << (int'(f3) % 4);
        fault = !legal || (a + size > 65536) || (!allow && (a % size) != 0);
        data  = '0;
        mask  = '0;
        if (!fault) begin
            if (we) begin
                for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = wdata[8*k +: 8];
                mask = 4'((1 << size) - 1);
            end else begin
                v = 0;
                for (int k = 0; k < size; k++) v = v + (longint'(ref_mem[int'(a) + k]) << (8*k));
                if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8*size - 1)))
                    v = v - (longint'(1) << (8*size));
                data = v[31:0];
            end
        end
    endtask

    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag, output logic [31:0] got);
        bit          efault;
        logic [31:0] edata;
        logic [3:0]  emask, seen, wen1;
        logic [15:0] addr1;
        int          lat;
        ref_access(we, f3, addr, wdata, 1'b1, efault, edata, emask);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_tag = tag;
        req_valid = 1'b1;
        #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat   = 1;
        seen  = mif.mem_w_en;
        wen1  = mif.mem_w_en;
        addr1 = mif.mem_address;
        while (!rsp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            seen = seen | mif.mem_w_en;
        end
        check("latency", 32'(lat), efault ? 32'd1 : 32'd2);
        if (efault) begin
            check("fault_no_wen", 32'(seen), 32'd0);
        end else begin
            check("access_wen", 32'(wen1), 32'(emask));
            check("access_addr", 32'(addr1), {16'd0, addr[15:0]});
        end
        check("rsp_fault", 32'(rsp_fault), 32'(efault));
        check("rsp_data", rsp_data, edata);
        check("rsp_tag", 32'(rsp_tag), 32'(tag));
        got = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [2:0]  st_f3    [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic        st_we    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] st_addr  [4] = '{32'h0101, 32'h0102, 32'h0100, 32'h0104};
    logic        st_fault [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] st_data  [4] = '{32'h0, 32'h0, 32'hFFFF_8001, 32'h0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, ea, eb;
        bit          fa, fb;
        logic [3:0]  ma, mb;
        int          lat;
        logic [31:0] raddr;
        int          sel;

        rst = 1'b1;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_tag = 0; rsp_ready = 0;
        s_req_valid = 0; s_req_we = 0; s_req_funct3 = 0; s_req_addr = 0; s_req_wdata = 0; s_req_tag = 0;
        s_rsp_ready = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i];
            mem[65472 + i] = 8'($urandom); ref_mem[65472 + i] = mem[65472 + i];
        end
        mem[16'h0200] = 8'h80; ref_mem[16'h0200] = 8'h80;
        mem[16'h0201] = 8'hFF; ref_mem[16'h0201] = 8'hFF;

        @(posedge clk); #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_w_en", 32'(mif.mem_w_en), 32'd0);
        check("rst_address", 32'(mif.mem_address), 32'd0);
        check("rst_write_data", mif.mem_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_req(1'b1, 3'd2, 32'h0100, 32'hDEADBEEF, 5'd1, got);
        check("sw_byte0", 32'(mem[16'h0100]), 32'hEF);
        check("sw_byte1", 32'(mem[16'h0101]), 32'hBE);
        check("sw_byte2", 32'(mem[16'h0102]), 32'hAD);
        check("sw_byte3", 32'(mem[16'h0103]), 32'hDE);

        run_req(1'b0, 3'd0, 32'h0200, 32'h0, 5'd2, got); check("lb_const", got, 32'hFFFF_FF80);
        run_req(1'b0, 3'd4, 32'h0200, 32'h0, 5'd3, got); check("lbu_const", got, 32'h0000_0080);
        run_req(1'b0, 3'd1, 32'h0200, 32'h0, 5'd4, got); check("lh_const", got, 32'hFFFF_FF80);
        run_req(1'b0, 3'd5, 32'h0200, 32'h0, 5'd5, got); check("lhu_const", got, 32'h0000_FF80);

        run_req(1'b1, 3'd0, 32'h0103, 32'h12345678, 5'd6, got);
        check("sb_target", 32'(mem[16'h0103]), 32'h78);
        check("sb_keep_102", 32'(mem[16'h0102]), 32'hAD);
        check("sb_keep_104", 32'(mem[16'h0104]), 32'h00);

        run_req(1'b0, 3'd2, 32'h0000FFFD, 32'h0, 5'd7, got);
        run_req(1'b0, 3'd2, 32'h00010000, 32'h0, 5'd8, got);
        run_req(1'b0, 3'd3, 32'h00000000, 32'h0, 5'd9, got);
        run_req(1'b1, 3'd1, 32'h0000FFFF, 32'h0, 5'd10, got);
        run_req(1'b1, 3'd4, 32'h00000010, 32'h0, 5'd11, got);
        run_req(1'b0, 3'd0, 32'h0000FFFF, 32'h0, 5'd12, got);
        run_req(1'b0, 3'd2, 32'h0000FFFC, 32'h0, 5'd13, got);

        // Backpressure: A stalls in RESP while B waits on req_valid.
        ref_access(1'b0, 3'd2, 32'h0100, 32'h0, 1'b1, fa, ea, ma);
        ref_access(1'b0, 3'd5, 32'h0200, 32'h0, 1'b1, fb, eb, mb);
        req_we = 0; req_funct3 = 3'd2; req_addr = 32'h0100; req_tag = 5'd14; req_valid = 1;
        @(posedge clk); #1;
        req_funct3 = 3'd5; req_addr = 32'h0200; req_tag = 5'd15;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_data", rsp_data, ea);
            check("bp_rsp_tag", 32'(rsp_tag), 32'd14);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0; rsp_ready = 0;
        check("bp_b_access_valid", 32'(rsp_valid), 32'd0);
        check("bp_b_access_addr", 32'(mif.mem_address), 32'h0200);
        check("bp_b_access_wen", 32'(mif.mem_w_en), 32'd0);
        @(posedge clk); #1;
        check("bp_b_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_b_rsp_data", rsp_data, eb);
        check("bp_b_rsp_tag", 32'(rsp_tag), 32'd15);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset lands mid-ACCESS of SW 0x0300; the reference memory is left untouched.
        req_we = 1; req_funct3 = 3'd2; req_addr = 32'h0300; req_wdata = 32'hCAFEF00D; req_tag = 5'd16;
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        check("rstmid_wen_before", 32'(mif.mem_w_en), 32'hF);
        rst = 1'b1;
        #1;
        check("rstmid_wen", 32'(mif.mem_w_en), 32'd0);
        check("rstmid_address", 32'(mif.mem_address), 32'd0);
        check("rstmid_wdata", mif.mem_write_data, 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_rsp_data", rsp_data, 32'd0);
        check("rstmid_rsp_tag", 32'(rsp_tag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) check("rstmid_mem", 32'(mem[16'h0300 + 16'(k)]), 32'(ref_mem[16'h0300 + k]));
        run_req(1'b0, 3'd2, 32'h0300, 32'h0, 5'd17, got);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      raddr = 32'($urandom_range(0, 63));
            else if (sel < 8) raddr = 32'h0000_FFF8 + 32'($urandom_range(0, 7));
            else if (sel < 9) raddr = 32'h0000_0200 + 32'($urandom_range(0, 3));
            else              raddr = $urandom;
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), raddr, $urandom,
                    5'($urandom_range(0, 31)), got);
        end

        for (int i = 0; i < 64; i++) begin
            check("scan_low", 32'(mem[i]), 32'(ref_mem[i]));
            check("scan_high", 32'(mem[65472 + i]), 32'(ref_mem[65472 + i]));
        end

        for (int i = 0; i < 4; i++) begin
            s_req_we = st_we[i]; s_req_funct3 = st_f3[i]; s_req_addr = st_addr[i];
            s_req_wdata = 32'h0; s_req_tag = 5'(20 + i); s_req_valid = 1'b1;
            @(posedge clk); #1;
            s_req_valid = 1'b0;
            lat = 1;
            while (!s_rsp_valid && lat < 6) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("strict%0d_latency", i), 32'(lat), st_fault[i] ? 32'd1 : 32'd2);
            check($sformatf("strict%0d_fault", i), 32'(s_rsp_fault), 32'(st_fault[i]));
            check($sformatf("strict%0d_data", i), s_rsp_data, st_data[i]);
            check($sformatf("strict%0d_tag", i), 32'(s_rsp_tag), 32'(20 + i));
            s_rsp_ready = 1'b1;
            @(posedge clk); #1;
            s_rsp_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit: the initiator side of the byte-addressed instruction/data memory port (4-bit byte write-enable, 16-bit byte address, 32-bit write data, combinational read when the write-enable is zero).
- Sits between the pipeline MEM stage and the data memory.
- Accepts one load/store request per valid/ready handshake, drives one memory access cycle and registers the result.
- Extracts and sign/zero-extends load data, flags illegal accesses, and returns a tagged response through a valid/ready handshake.

Parameters:
- ADDR_W, 16, memory byte-address width; the top usable byte is 2^ADDR_W-1.
- TAG_W, 5, width of the destination-register tag carried from request to response.
- ALLOW_MISALIGNED, 1, 1 = misaligned H/W accesses are legal; 0 = they fault.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_tag  in  TAG_W  destination tag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  32  extended load data; 0 for stores and faults.
- rsp_tag  out  TAG_W  tag of the request.
- rsp_fault  out  1  access rejected.
- mem_w_en  out  4  byte write enables, relative to mem_address (bit k writes byte address+k).
- mem_address  out  ADDR_W  byte address.
- mem_write_data  out  32  write data, byte k on bits [8k+7:8k].
- mem_read_data  in  32  combinational read data, byte k = mem[address+k].

Behaviour:
- Reset (async, any state): state=IDLE; rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_fault=0; mem_w_en=0, mem_address=0, mem_write_data=0. A reset mid-ACCESS aborts the access: w_en drops immediately and no byte is written.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/funct3/addr/wdata/tag and evaluate faults.
  - No fault -> ACCESS. Fault -> RESP with rsp_fault=1, rsp_data=0; the memory is never touched.
- Fault conditions:
  - Load funct3 in {3,6,7}, or store funct3 > 2.
  - req_addr[31:ADDR_W] != 0.
  - addr[ADDR_W-1:0] + size - 1 > 2^ADDR_W-1 (no wrap allowed; e.g. LW at 0xFFFD faults).
  - ALLOW_MISALIGNED=0 and (H with addr[0]=1, or W with addr[1:0]!=0).
- ACCESS (exactly one cycle):
  - mem_address = captured address.
  - Store: mem_w_en = 0001 (B), 0011 (H) or 1111 (W); mem_write_data = captured wdata. The write commits at the clock edge ending ACCESS.
  - Load: mem_w_en=0; mem_read_data sampled at the same edge.
    - B: byte0, sign- or zero-extended per funct3.
    - H: bytes1:0, sign- or zero-extended per funct3.
    - W: as is.
  - Next state RESP.
- Outside ACCESS: mem_w_en=0, mem_address=0, mem_write_data=0.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - On rsp_ready: if req_valid is also high, req_ready=1, the new request is captured and the FSM goes straight to ACCESS (or RESP if it faults); otherwise -> IDLE.
  - req_ready = rsp_ready while in RESP.
- Latency: request accepted at edge N -> rsp_valid high after edge N+2 (after N+1 for faults).
- Throughput: with rsp_ready held high, one request every 2 cycles.
- Stores also return a response (rsp_data=0) so the pipeline sees completion.
- Responses never reorder; at most one request is outstanding.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5).
  - State encoding enum (IDLE/ACCESS/RESP).
  - size_of(funct3) function.
- One sub-module, lsu_load_extend: combinational funct3 + 32-bit raw -> 32-bit extended data. Reused by any future cache path.

Test Plan:
- After reset, SW addr=0x0100 data=0xDEADBEEF -> ACCESS drives w_en=1111, address=0x0100; bytes 0x100..0x103 become EF,BE,AD,DE; rsp_valid after 2 cycles, rsp_fault=0.
- Memory bytes 0x200=0x80, 0x201=0xFF: LB 0x200 -> 0xFFFFFF80; LBU -> 0x00000080; LH -> 0xFFFFFF80; LHU -> 0x0000FF80.
- SB addr=0x0103 data=0x12345678 -> w_en=0001, only 0x103=0x78; the neighbouring bytes are unchanged.
- LW 0xFFFD, LW 0x00010000, load funct3=3 -> each gives rsp_fault=1, rsp_data=0, 1-cycle latency, and mem_w_en never nonzero. With ALLOW_MISALIGNED=0, LH 0x0101 also faults.
- rsp_ready held low 5 cycles with req_valid high -> rsp_* stable and req_ready=0; releasing rsp_ready -> the next request is captured the same cycle and ACCESS follows the next cycle.
- Assert rst during ACCESS of SW 0x0300 -> no byte written at 0x300..0x303; all outputs return to their reset values immediately.
